shift_arbiter: RTL

Shares one 32-bit left barrel shifter (`BarrelShifter`, with a fill bit shifted in from the LSB side) among `NREQ` requesters. Uses round-robin arbitration, a two-stage registered pipeline and a valid/ready response port with backpressure. It sits between the execution clients and the single shifter instance, so the shifter never needs duplicating.

---
 rtl/shift_pkg.sv | 29 ++
 rtl/barrel_shifter.sv | 25 ++
 rtl/shift_arbiter_rr_pick.sv | 34 +++
 rtl/shift_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift_arbiter slice: datapath widths,
// the operand bundle carried through the operand stage, and the
// round-robin pointer update.
package shift_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] amount;
    logic               fill;
  } shift_op_t;

  // Pointer moves to the slot just past the winner so the winner becomes
  // lowest priority; an out-of-range grant leaves the pointer where it was.
  function automatic int unsigned next_ptr(input int unsigned ptr,
                                           input int unsigned grant,
                                           input int unsigned nreq);
    int unsigned nxt;
    if (grant < nreq) begin
      nxt = (grant + 32'd1) % nreq;
    end else begin
      nxt = ptr;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// 32-bit logarithmic left shifter. Vacated LSBs are filled with the fill
// bit, so a fill of 1 ORs in a mask of (1 << amount) - 1.
module BarrelShifter
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               fill,
  output logic [WIDTH-1:0]   result
);

  logic [SHAMT_W:0][WIDTH-1:0] stage_s;

  assign stage_s[0] = data;

  // Stage s shifts by 2**s when amount bit s is set.
  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign stage_s[s+1] = amount[s] ? {stage_s[s][WIDTH-1-SH:0], {SH{fill}}}
                                    : stage_s[s];
  end

  assign result = stage_s[SHAMT_W];

endmodule

// File: rtl/shift_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first asserted request at
// or above ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  grant,
  output logic            any
);

  int   idx_s;
  logic found_s;

  // Walk NREQ slots starting at ptr and latch the first requester seen.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(ptr) + k) % NREQ;
      if (!found_s && req[idx_s]) begin
        grant   = IDW'(idx_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NREQ requesters.
// S1 registers the granted operands and feeds the shifter; S2 registers
// the result and drives the response port straight from flops.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                         Clock,
  input  logic                         Reset_N,
  input  logic [NREQ-1:0]              ReqValid,
  input  logic [NREQ-1:0][WIDTH-1:0]   ReqData,
  input  logic [NREQ-1:0][SHAMT_W-1:0] ReqAmount,
  input  logic [NREQ-1:0]              ReqShiftIn,
  output logic [NREQ-1:0]              ReqReady,
  output logic                         RspValid,
  output logic [WIDTH-1:0]             RspData,
  output logic [IDW-1:0]               RspId,
  input  logic                         RspReady
);

  logic [IDW-1:0]   grant_s;
  logic             any_s;
  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             acc_ok_s;
  logic             accept_s;
  shift_op_t        req_op_s;
  logic [WIDTH-1:0] shift_res_s;

  logic             s1_valid_r;
  shift_op_t        s1_op_r;
  logic [IDW-1:0]   s1_id_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_data_r;
  logic [IDW-1:0]   s2_id_r;
  logic [IDW-1:0]   ptr_r;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (ReqValid),
    .ptr   (ptr_r),
    .grant (grant_s),
    .any   (any_s)
  );

  BarrelShifter u_shift (
    .data   (s1_op_r.data),
    .amount (s1_op_r.amount),
    .fill   (s1_op_r.fill),
    .result (shift_res_s)
  );

  // S2 frees up when empty or draining; S1 can take a new op when empty or moving on.
  assign s2_adv_s = !s2_valid_r || RspReady;
  assign s1_adv_s = s1_valid_r && s2_adv_s;
  assign acc_ok_s = !s1_valid_r || s1_adv_s;
  assign accept_s = acc_ok_s && any_s;

  // Select the granted requester's operands for loading into S1.
  always_comb begin
    req_op_s        = '0;
    req_op_s.data   = ReqData[grant_s];
    req_op_s.amount = ReqAmount[grant_s];
    req_op_s.fill   = ReqShiftIn[grant_s];
  end

  // Ready goes only to the current winner, and only when S1 can take it.
  always_comb begin
    ReqReady = '0;
    if (accept_s) begin
      ReqReady[grant_s] = 1'b1;
    end else begin
      ReqReady = '0;
    end
  end

  // Operand stage: load on accept, otherwise empty out once it has advanced.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= '0;
      s1_id_r    <= '0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= req_op_s;
      s1_id_r    <= grant_s;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Result stage: capture the shifter output when S1 advances, clear on drain.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= '0;
      s2_id_r    <= '0;
    end else if (s1_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_data_r  <= shift_res_s;
      s2_id_r    <= s1_id_r;
    end else if (RspReady) begin
      s2_valid_r <= 1'b0;
    end
  end

  // Round-robin pointer only moves when a request is actually accepted.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      ptr_r <= '0;
    end else if (accept_s) begin
      ptr_r <= IDW'(next_ptr(32'(ptr_r), 32'(grant_s), NREQ));
    end
  end

  assign RspValid = s2_valid_r;
  assign RspData  = s2_data_r;
  assign RspId    = s2_id_r;

endmodule
